ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single read port (raddr_0/rdata_0) and single write port (waddr_0/wen_0/wdata_0) of the RAM block among NUM_REQ kernel requesters, such as read_write_ram instances.
- Round-robin arbitration; at most one RAM operation (read or write) is issued per cycle.
- Read data is routed back to the issuing requester after RD_LATENCY cycles.
- Sits between the kernels and RAM; the RAM debug ports are untouched.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, RAM address width.
- DATA_W, 32, RAM data width.
- RD_LATENCY, 1, cycles from read address presentation to valid ram_rdata_0 (1..4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready at a rising edge.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_data  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid.
- ram_raddr_0  out  ADDR_W  RAM read address.
- ram_rdata_0  in  DATA_W  RAM read data.
- ram_waddr_0  out  ADDR_W  RAM write address.
- ram_wen_0  out  1  RAM write enable.
- ram_wdata_0  out  DATA_W  RAM write data.
- busy  out  1  1 while any read response is in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr is set to NUM_REQ-1, so requester 0 has priority first.
  - The response pipeline is cleared.
  - req_ready, rsp_valid, ram_wen_0 and busy are 0; ram_raddr_0, ram_waddr_0, ram_wdata_0 and rsp_data are 0.
- Arbitration (combinational each cycle):
  - Search starts at index rr_ptr+1 (mod NUM_REQ); the first i with req_valid[i]=1 is granted.
  - req_ready = one-hot of the granted index, or 0 if no valid request.
  - req_ready never asserts for a requester whose req_valid=0.
- Pointer update: on each edge where a grant occurs, rr_ptr <= granted index. With no grant, rr_ptr holds.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0,... Max wait is NUM_REQ-1 cycles.
- Write grant:
  - Same cycle: ram_wen_0=1, ram_waddr_0=req_addr[g], ram_wdata_0=req_wdata[g]. The RAM commits at the edge.
  - No response is generated.
- Read grant:
  - Same cycle: ram_raddr_0=req_addr[g]; ram_wen_0=0.
  - Grant index and a valid bit are pushed into a RD_LATENCY-deep shift register.
- Response timing:
  - For a read granted at edge k, the cycle after edge k+RD_LATENCY-1 has rsp_valid[g]=1 and rsp_data=ram_rdata_0 (combinational pass-through).
  - Back-to-back reads yield back-to-back responses in grant order.
- Idle outputs:
  - ram_wen_0=0 in every cycle without a write grant.
  - ram_raddr_0 and ram_waddr_0 hold their last driven values (registered hold mux) to avoid toggling.
- No ordering hazard logic:
  - A write at edge k followed by a read of the same address at edge k+1 returns whatever the RAM returns.
  - RAM is write-then-read across edges, so the new data is returned.
- busy = OR of the shift-register valid bits.
- Reset mid-operation: in-flight responses are discarded and never reach requesters. A write granted in the cycle rst falls is not guaranteed.
- Requesters must hold req_valid, addr and data stable until granted. The arbiter does not check this.

Decomposition:
- Shared package ram_arb_pkg:
  - Constant MAX_REQ=8.
  - Function clog2 for the index width.
  - Typedef for the response-pipeline entry {valid, idx}.
- One natural sub-module, rr_arbiter: pure round-robin pick from req_valid and rr_ptr producing a one-hot grant plus the index. It is reusable for other shared resources.

Test Plan:
- Reset: hold rst=0, drive req_valid=2'b11 -> req_ready=0, ram_wen_0=0, rsp_valid=0, busy=0. Release rst -> the first grant goes to requester 0.
- Single write then read: req0 writes addr 10 data 15, then reads addr 10 -> ram_wen_0=1 with waddr 10 and wdata 15 in the grant cycle. rsp_valid=2'b01 and rsp_data=15 exactly 1 cycle after the read grant; busy=1 meanwhile.
- Contention: both valid for 4 cycles, both reads (addr 12, 13) -> req_ready sequence 01,10,01,10. Responses arrive in the same alternating order with the correct data.
- Mixed write/read: req0 writes addr 12 data 15 while req1 reads addr 12. Grants are serialized: write, then read -> rsp_valid=2'b10, rsp_data=15.
- Latency sweep with RD_LATENCY=3 and NUM_REQ=4: 4 back-to-back reads from reqs 0..3 -> responses at grant+3 in order 0,1,2,3; busy falls one cycle after the last response.
- Reset mid-flight: read granted, then rst=0 before the response -> no rsp_valid pulse, busy=0 immediately. After release, rr_ptr restarts at requester 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants, helpers and types for the RAM port arbiter and its
// round-robin picker.
package ram_arb_pkg;

    localparam int MAX_REQ = 8;

    // Index width for n items, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int RSP_IDX_W = clog2(MAX_REQ);

    typedef struct packed {
        logic                 valid;
        logic [RSP_IDX_W-1:0] idx;
    } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first valid requester after rr_ptr,
// returning the grant both one-hot and as an index.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(rr_ptr) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM read port and one RAM write port among NUM_REQ requesters,
// issuing at most one operation per cycle and routing read data back.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         ram_raddr_0,
    input  logic [DATA_W-1:0]         ram_rdata_0,
    output logic [ADDR_W-1:0]         ram_waddr_0,
    output logic                      ram_wen_0,
    output logic [DATA_W-1:0]         ram_wdata_0,
    output logic                      busy
);

    localparam int IDX_W = clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant_any;
    logic               sel_we;
    logic               wr_grant;
    logic               rd_grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [ADDR_W-1:0]  raddr_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    rsp_entry_t         rsp_pipe [RD_LATENCY];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign req_ready = rst ? pick : '0;
    assign grant_any = rst & pick_any;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_grant = grant_any & sel_we;
    assign rd_grant = grant_any & ~sel_we;

    // Address and data buses hold their last driven value while idle.
    assign ram_wen_0   = wr_grant;
    assign ram_waddr_0 = wr_grant ? sel_addr  : waddr_q;
    assign ram_wdata_0 = wr_grant ? sel_wdata : wdata_q;
    assign ram_raddr_0 = rd_grant ? sel_addr  : raddr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= IDX_W'(NUM_REQ - 1);
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            // NOTE: the response pipeline is reset so in-flight reads are dropped rather than replayed after reset.
            for (int i = 0; i < RD_LATENCY; i++) begin
                rsp_pipe[i] <= '0;
            end
        end else begin
            if (grant_any) rr_ptr <= pick_idx;
            if (rd_grant) raddr_q <= sel_addr;
            if (wr_grant) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
            rsp_pipe[0] <= '{valid: rd_grant, idx: RSP_IDX_W'(pick_idx)};
            for (int i = 1; i < RD_LATENCY; i++) begin
                rsp_pipe[i] <= rsp_pipe[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_pipe[RD_LATENCY-1].valid &&
                           (rsp_pipe[RD_LATENCY-1].idx == RSP_IDX_W'(i));
        end
    end

    assign rsp_data = rsp_pipe[RD_LATENCY-1].valid ? ram_rdata_0 : '0;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy = busy | rsp_pipe[i].valid;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (2 requesters / latency 1 and
// 4 requesters / latency 3) on behavioural RAMs, checked every cycle.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus indexed [instance][requester]; instance 0 = A, 1 = B.
    logic [3:0]    drv_valid [2];
    logic [3:0]    drv_we    [2];
    logic [AW-1:0] drv_addr  [2][4];
    logic [DW-1:0] drv_wdata [2][4];

    logic [1:0]    a_ready, a_rsp_valid;
    logic [DW-1:0] a_rsp_data, a_wdata;
    logic [AW-1:0] a_raddr, a_waddr;
    logic          a_wen, a_busy;
    logic [3:0]    b_ready, b_rsp_valid;
    logic [DW-1:0] b_rsp_data, b_wdata;
    logic [AW-1:0] b_raddr, b_waddr;
    logic          b_wen, b_busy;

    logic [DW-1:0] mem     [2][256];
    logic [DW-1:0] rd_pipe [2][3];

    ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (drv_valid[0][1:0]),
        .req_we      (drv_we[0][1:0]),
        .req_addr    ({drv_addr[0][1], drv_addr[0][0]}),
        .req_wdata   ({drv_wdata[0][1], drv_wdata[0][0]}),
        .req_ready   (a_ready),
        .rsp_valid   (a_rsp_valid),
        .rsp_data    (a_rsp_data),
        .ram_raddr_0 (a_raddr),
        .ram_rdata_0 (rd_pipe[0][0]),
        .ram_waddr_0 (a_waddr),
        .ram_wen_0   (a_wen),
        .ram_wdata_0 (a_wdata),
        .busy        (a_busy)
    );

    ram_port_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (drv_valid[1]),
        .req_we      (drv_we[1]),
        .req_addr    ({drv_addr[1][3], drv_addr[1][2], drv_addr[1][1], drv_addr[1][0]}),
        .req_wdata   ({drv_wdata[1][3], drv_wdata[1][2], drv_wdata[1][1], drv_wdata[1][0]}),
        .req_ready   (b_ready),
        .rsp_valid   (b_rsp_valid),
        .rsp_data    (b_rsp_data),
        .ram_raddr_0 (b_raddr),
        .ram_rdata_0 (rd_pipe[1][2]),
        .ram_waddr_0 (b_waddr),
        .ram_wen_0   (b_wen),
        .ram_wdata_0 (b_wdata),
        .busy        (b_busy)
    );

    logic [3:0]    o_ready [2], o_rsp [2];
    logic [DW-1:0] o_data  [2], o_wdata [2];
    logic [AW-1:0] o_raddr [2], o_waddr [2];
    logic          o_wen   [2], o_busy  [2];

    always_comb begin
        o_ready[0] = {2'b00, a_ready};      o_ready[1] = b_ready;
        o_rsp[0]   = {2'b00, a_rsp_valid};  o_rsp[1]   = b_rsp_valid;
        o_data[0]  = a_rsp_data;            o_data[1]  = b_rsp_data;
        o_wdata[0] = a_wdata;               o_wdata[1] = b_wdata;
        o_raddr[0] = a_raddr;               o_raddr[1] = b_raddr;
        o_waddr[0] = a_waddr;               o_waddr[1] = b_waddr;
        o_wen[0]   = a_wen;                 o_wen[1]   = b_wen;
        o_busy[0]  = a_busy;                o_busy[1]  = b_busy;
    end

    function automatic int nreq(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // RAM port values captured mid-cycle and applied by the RAM at the next edge.
    logic [AW-1:0] s_raddr [2], s_waddr [2];
    logic [DW-1:0] s_wdata [2];
    logic          s_wen   [2];

    // Read-first RAM with a read pipeline of lat(d) stages.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 1; k < 3; k++) rd_pipe[d][k] <= rd_pipe[d][k-1];
            rd_pipe[d][0] <= mem[d][s_raddr[d]];
            if (s_wen[d]) mem[d][s_waddr[d]] <= s_wdata[d];
        end
    end

    // Reference model: pending reads carry the cycle their response is due.
    typedef struct {
        int            d;
        int            idx;
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend_q [$];
    int            last_grant [2];
    logic [AW-1:0] m_raddr [2], m_waddr [2];
    logic [DW-1:0] m_wdata [2];
    logic [3:0]    granted [2];
    int            cyc;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int            n;
        int            g;
        logic [3:0]    e_ready;
        logic [3:0]    e_rsp;
        logic [DW-1:0] e_data;
        logic          e_busy;
        logic          e_wen;
        string         p;
        n       = nreq(d);
        g       = -1;
        e_ready = '0;
        e_rsp   = '0;
        e_data  = '0;
        e_busy  = 1'b0;
        e_wen   = 1'b0;
        p       = (d == 0) ? "A" : "B";
        if (!rst) begin
            last_grant[d] = n - 1;
            m_raddr[d]    = '0;
            m_waddr[d]    = '0;
            m_wdata[d]    = '0;
            for (int k = pend_q.size() - 1; k >= 0; k--)
                if (pend_q[k].d == d) pend_q.delete(k);
        end else begin
            for (int off = 1; off <= n && g < 0; off++)
                if (drv_valid[d][(last_grant[d] + off) % n]) g = (last_grant[d] + off) % n;
        end
        foreach (pend_q[k]) begin
            if (pend_q[k].d == d && pend_q[k].due >= cyc) begin
                e_busy = 1'b1;
                if (pend_q[k].due == cyc) begin
                    e_rsp[pend_q[k].idx] = 1'b1;
                    e_data               = pend_q[k].data;
                end
            end
        end
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            if (drv_we[d][g]) begin
                e_wen      = 1'b1;
                m_waddr[d] = drv_addr[d][g];
                m_wdata[d] = drv_wdata[d][g];
            end else begin
                m_raddr[d] = drv_addr[d][g];
            end
        end
        check($sformatf("%s req_ready", p), o_ready[d], e_ready);
        check($sformatf("%s rsp_valid", p), o_rsp[d], e_rsp);
        check($sformatf("%s busy", p), o_busy[d], e_busy);
        check($sformatf("%s ram_wen_0", p), o_wen[d], e_wen);
        check($sformatf("%s ram_raddr_0", p), o_raddr[d], m_raddr[d]);
        check($sformatf("%s ram_waddr_0", p), o_waddr[d], m_waddr[d]);
        if (e_wen || !rst) check($sformatf("%s ram_wdata_0", p), o_wdata[d], m_wdata[d]);
        if (e_rsp != 0 || !rst) check($sformatf("%s rsp_data", p), o_data[d], e_data);
        if (g >= 0) begin
            last_grant[d] = g;
            if (!drv_we[d][g])
                pend_q.push_back('{d: d, idx: g, due: cyc + lat(d), data: mem[d][drv_addr[d][g]]});
        end
        for (int k = pend_q.size() - 1; k >= 0; k--)
            if (pend_q[k].d == d && pend_q[k].due <= cyc) pend_q.delete(k);
        granted[d] = e_ready;
        s_raddr[d] = o_raddr[d];
        s_waddr[d] = o_waddr[d];
        s_wdata[d] = o_wdata[d];
        s_wen[d]   = o_wen[d];
    endtask

    always @(negedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = '0;
            drv_we[d]    = '0;
            for (int i = 0; i < 4; i++) begin
                drv_addr[d][i]  = '0;
                drv_wdata[d][i] = '0;
            end
        end
    endtask

    task automatic set_req(input int d, input int i, input bit we, input int addr, input int data);
        drv_valid[d][i] = 1'b1;
        drv_we[d][i]    = we;
        drv_addr[d][i]  = AW'(addr);
        drv_wdata[d][i] = DW'(data);
    endtask

    // Each requester holds its request until granted, then may issue a new one.
    task automatic drive_random();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nreq(d); i++) begin
                if (granted[d][i]) drv_valid[d][i] = 1'b0;
                if (!drv_valid[d][i] && $urandom_range(0, 99) < 40)
                    set_req(d, i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int d = 0; d < 2; d++) begin
            last_grant[d] = nreq(d) - 1;
            m_raddr[d]    = '0;
            m_waddr[d]    = '0;
            m_wdata[d]    = '0;
            granted[d]    = '0;
            s_raddr[d]    = '0;
            s_waddr[d]    = '0;
            s_wdata[d]    = '0;
            s_wen[d]      = 1'b0;
            for (int a = 0; a < 256; a++) mem[d][a] <= DW'($urandom);
            for (int k = 0; k < 3; k++) rd_pipe[d][k] <= '0;
        end
        clear_all();
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset with everyone requesting: nothing may be granted.
        set_req(0, 0, 0, 0, 0);
        set_req(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) set_req(1, i, 0, i, 0);
        repeat (2) @(negedge clk);
        check("A reset req_ready", a_ready, 2'b00);
        check("A reset ram_wen_0", a_wen, 1'b0);
        check("A reset rsp_valid", a_rsp_valid, 2'b00);
        check("A reset busy", a_busy, 1'b0);
        check("B reset req_ready", b_ready, 4'b0000);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("A first grant", a_ready, 2'b01);
        check("B first grant", b_ready, 4'b0001);
        tick();
        clear_all();
        repeat (4) tick();

        // Single write then read of the same address.
        set_req(0, 0, 1, 10, 15);
        @(negedge clk);
        check("A wr req_ready", a_ready, 2'b01);
        check("A wr ram_wen_0", a_wen, 1'b1);
        check("A wr ram_waddr_0", a_waddr, 10);
        check("A wr ram_wdata_0", a_wdata, 15);
        tick();
        drv_we[0][0] = 1'b0;
        @(negedge clk);
        check("A rd req_ready", a_ready, 2'b01);
        check("A rd ram_wen_0", a_wen, 1'b0);
        check("A rd ram_raddr_0", a_raddr, 10);
        tick();
        clear_all();
        @(negedge clk);
        check("A rd rsp_valid", a_rsp_valid, 2'b01);
        check("A rd rsp_data", a_rsp_data, 15);
        check("A rd busy", a_busy, 1'b1);
        tick();
        @(negedge clk);
        check("A idle rsp_valid", a_rsp_valid, 2'b00);
        check("A idle busy", a_busy, 1'b0);
        tick();

        // Contention: known data at 12/13, then both requesters read continuously.
        set_req(0, 0, 1, 12, 16'hAAAA);
        tick();
        clear_all();
        set_req(0, 1, 1, 13, 16'h5555);
        tick();
        clear_all();
        set_req(0, 0, 0, 12, 0);
        set_req(0, 1, 0, 13, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) check($sformatf("A contention grant %0d", k), a_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                check($sformatf("A contention rsp %0d", k), a_rsp_valid, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("A contention data %0d", k), a_rsp_data, ((k - 1) % 2 == 0) ? 16'hAAAA : 16'h5555);
            end
            tick();
            if (k == 3) clear_all();
        end

        // Write and read of the same address requested together are serialized.
        set_req(0, 0, 1, 12, 15);
        set_req(0, 1, 0, 12, 0);
        @(negedge clk);
        check("A mixed grant write", a_ready, 2'b01);
        check("A mixed ram_wen_0", a_wen, 1'b1);
        tick();
        drv_valid[0][0] = 1'b0;
        @(negedge clk);
        check("A mixed grant read", a_ready, 2'b10);
        check("A mixed read wen", a_wen, 1'b0);
        check("A mixed ram_raddr_0", a_raddr, 12);
        tick();
        clear_all();
        @(negedge clk);
        check("A mixed rsp_valid", a_rsp_valid, 2'b10);
        check("A mixed rsp_data", a_rsp_data, 15);
        repeat (4) tick();

        // Reset while a read is in flight on B.
        set_req(1, 2, 0, 5, 0);
        @(negedge clk);
        check("B inflight grant", b_ready, 4'b0100);
        tick();
        clear_all();
        @(negedge clk);
        check("B inflight busy", b_busy, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("B reset busy", b_busy, 1'b0);
        check("B reset rsp_valid", b_rsp_valid, 4'b0000);
        tick();
        @(negedge clk);
        check("B dropped rsp_valid", b_rsp_valid, 4'b0000);
        tick();
        rst = 1'b1;

        // Latency sweep on B: four back-to-back reads starting from requester 0.
        for (int i = 0; i < 4; i++) set_req(1, i, 0, 20 + i, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) check($sformatf("B sweep grant %0d", k), b_ready, 1 << k);
            check($sformatf("B sweep rsp %0d", k), b_rsp_valid, (k >= 3 && k <= 6) ? (1 << (k - 3)) : 0);
            check($sformatf("B sweep busy %0d", k), b_busy, (k >= 1 && k <= 6) ? 1 : 0);
            tick();
            if (k < 4) drv_valid[1][k] = 1'b0;
        end

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end
        clear_all();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
